// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - six-button synchroniser, debouncer, press pulse and auto-repeat stage
//
// Conditions the raw active-low watch buttons for the mode/setting logic.
// Bit order of every 6-bit bus: {esc, enter, right, left, down, up}.
//
// Ports:
//   clk        in   1  system clock (1 MHz)
//   rst_n      in   1  asynchronous active-low reset
//   btn_n_i    in   6  raw pad inputs, active-low
//   btn_level  out  6  debounced state, 1 = held
//   btn_press  out  6  one-cycle pulse on accepted press and on each auto-repeat
//   btn_rpt    out  6  one-cycle flag marking a btn_press bit that came from auto-repeat
//   any_press  out  1  OR of btn_press
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYC  = 10000,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000,
  parameter logic [5:0]  REPEAT_MASK   = 6'b000011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_n_i,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic [5:0] btn_rpt,
  output logic       any_press
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(REPEAT_DELAY + 1);

  logic [5:0] s1_q;
  logic [5:0] s2_q;
  logic [5:0] samp_q;    // registered, inverted copy of s2: the sample the debouncer sees
  logic [5:0] stable_q;
  logic [5:0] stable_d;
  logic [5:0] rise;      // debounced 0->1 this cycle
  logic [5:0] rpt;       // auto-repeat pulse due this cycle
  logic [5:0] btn_press_q;
  logic [5:0] btn_rpt_q;
  logic       any_press_q;

  // Synchroniser and sample register. The sample register places the
  // first debounce count one edge after s2 settles, giving a press-to-level
  // latency of DEBOUNCE_CYC+2 edges from the first low raw sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 6'b111111;
      s2_q   <= 6'b111111;
      samp_q <= 6'b000000;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      samp_q <= ~s2_q;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_btn
    logic [DW-1:0] dcnt_q;
    logic          differ;
    logic          flip;

    assign differ = samp_q[i] != stable_q[i];
    assign flip   = differ && (dcnt_q == DW'(DEBOUNCE_CYC - 1));

    // Any return of samp to the stable value discards the partial count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_q <= '0;
      end else if (!differ || flip) begin
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + DW'(1);
      end
    end

    assign stable_d[i] = flip ? samp_q[i] : stable_q[i];
    assign rise[i]     = flip && samp_q[i];

    if (REPEAT_MASK[i]) begin : g_rep
      logic [HW-1:0] hcnt_q;
      logic          rep_phase_q;
      logic          due;

      assign due = stable_q[i] &&
                   (rep_phase_q ? (hcnt_q == HW'(REPEAT_PERIOD - 1))
                                : (hcnt_q == HW'(REPEAT_DELAY - 1)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt_q      <= '0;
          rep_phase_q <= 1'b0;
        end else if (!stable_q[i]) begin
          // Covers both the released state and the 0->1 flip cycle.
          hcnt_q      <= '0;
          rep_phase_q <= 1'b0;
        end else if (due) begin
          hcnt_q      <= '0;
          rep_phase_q <= 1'b1;
        end else begin
          hcnt_q      <= hcnt_q + HW'(1);
        end
      end

      // A debounced release in the same cycle suppresses the repeat pulse.
      assign rpt[i] = due && stable_d[i];
    end else begin : g_norep
      assign rpt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q    <= 6'b000000;
      btn_press_q <= 6'b000000;
      btn_rpt_q   <= 6'b000000;
      any_press_q <= 1'b0;
    end else begin
      stable_q    <= stable_d;
      btn_press_q <= rise | rpt;
      btn_rpt_q   <= rpt;
      any_press_q <= |(rise | rpt);
    end
  end

  assign btn_level = stable_q;
  assign btn_press = btn_press_q;
  assign btn_rpt   = btn_rpt_q;
  assign any_press = any_press_q;

endmodule
